// File: rtl/mnist_argmax.sv
// rtl/mnist_argmax.sv - argmax over framed signed activations, one class result per frame
//
// Purpose: groups NUM_CLASSES signed activations into a frame and reports the index
//          and value of the largest one (lowest index wins on a tie).
// Ports:
//   s_axi_aclk    clock, rising edge
//   s_axi_areset  synchronous active-high reset
//   a_tdata/a_tvalid/a_tready        activation input stream
//   class_tdata/class_tmax/class_tvalid/class_tready  result stream
//   frame_count   completed frames since reset (wraps)
//   busy          a frame is partially accumulated
module mnist_argmax #(
    parameter int DATA_W      = 32,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4,
    parameter int CNT_W       = 16
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    input  logic [DATA_W-1:0] a_tdata,
    input  logic              a_tvalid,
    output logic              a_tready,
    output logic [IDX_W-1:0]  class_tdata,
    output logic [DATA_W-1:0] class_tmax,
    output logic              class_tvalid,
    input  logic              class_tready,
    output logic [CNT_W-1:0]  frame_count,
    output logic              busy
);

    typedef enum logic {
        ST_ACCUM,
        ST_OUTPUT
    } state_t;

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_CLASSES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  best_val_q, best_val_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic beat;
    logic out_hs;

    assign beat   = a_tvalid & a_tready;
    assign out_hs = class_tvalid & class_tready;

    // State register
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: begin
                if (beat && (cnt_q == LAST_BEAT)) begin
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (out_hs) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // Output logic. a_tready is masked by reset so it reads 0 while reset is held,
    // even though the state register already sits in ACCUM.
    always_comb begin
        a_tready     = 1'b0;
        class_tvalid = 1'b0;
        busy         = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                a_tready = ~s_axi_areset;
                busy     = (cnt_q != '0);
            end
            ST_OUTPUT: begin
                class_tvalid = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next-state. Beat 0 loads unconditionally; later beats replace the
    // running best only on a strictly greater value, so ties keep the lower index.
    always_comb begin
        cnt_d       = cnt_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        frame_cnt_d = frame_cnt_q;
        if (beat) begin
            if ((cnt_q == '0) || ($signed(a_tdata) > $signed(best_val_q))) begin
                best_val_d = a_tdata;
                best_idx_d = cnt_q;
            end
            cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + IDX_W'(1);
        end
        if (out_hs) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            cnt_q       <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Best registers are held untouched in OUTPUT, which keeps the result stable
    // while the consumer stalls.
    assign class_tdata = best_idx_q;
    assign class_tmax  = best_val_q;
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_mnist_argmax.sv
// tb/tb_mnist_argmax.sv - self-checking bench for mnist_argmax
module tb_mnist_argmax;

    localparam int N = 10;

    logic        clk;
    logic        rst;
    logic [31:0] a_tdata;
    logic        a_tvalid;
    logic        a_tready;
    logic [3:0]  class_tdata;
    logic [31:0] class_tmax;
    logic        class_tvalid;
    logic        class_tready;
    logic [15:0] frame_count;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic mon_en = 1'b0;

    mnist_argmax dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .a_tdata      (a_tdata),
        .a_tvalid     (a_tvalid),
        .a_tready     (a_tready),
        .class_tdata  (class_tdata),
        .class_tmax   (class_tmax),
        .class_tvalid (class_tvalid),
        .class_tready (class_tready),
        .frame_count  (frame_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference argmax: first occurrence of the largest signed value.
    function automatic void argmax(input logic [31:0] v[N], output int idx, output logic [31:0] mx);
        idx = 0;
        mx  = v[0];
        for (int i = 1; i < N; i++) begin
            if ($signed(v[i]) > $signed(mx)) begin
                idx = i;
                mx  = v[i];
            end
        end
    endfunction

    // Cycle model: state reflects the DUT after the most recent rising edge.
    logic [31:0] m_beats[N];
    int          m_n = 0;
    logic        m_pend = 1'b0;
    int          m_idx = 0;
    logic [31:0] m_max = '0;
    logic [15:0] m_count = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_tvalid", 32'(class_tvalid), 32'(m_pend));
            check("mon_tready", 32'(a_tready), 32'(!m_pend && !rst));
            check("mon_frame_count", 32'(frame_count), 32'(m_count));
            check("mon_busy", 32'(busy), 32'(!m_pend && (m_n != 0)));
            if (m_pend) begin
                check("mon_tdata", 32'(class_tdata), 32'(m_idx));
                check("mon_tmax", class_tmax, m_max);
            end
        end
        if (rst) begin
            m_pend  = 1'b0;
            m_n     = 0;
            m_count = '0;
        end else if (m_pend) begin
            if (class_tready) begin
                m_pend  = 1'b0;
                m_count = m_count + 16'd1;
            end
        end else if (a_tvalid) begin
            m_beats[m_n] = a_tdata;
            m_n++;
            if (m_n == N) begin
                argmax(m_beats, m_idx, m_max);
                m_pend = 1'b1;
                m_n    = 0;
            end
        end
    end

    task automatic send_beat(input logic [31:0] v);
        logic hs;
        int   t;
        hs = 1'b0;
        t  = 0;
        a_tvalid = 1'b1;
        a_tdata  = v;
        while (!hs && t < 300) begin
            @(negedge clk);
            hs = a_tready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!hs) begin
            n_checks++;
            n_errors++;
            $display("FAIL beat_timeout: got no handshake expected handshake");
        end
        a_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] v[N], input int maxgap);
        for (int i = 0; i < N; i++) begin
            int g;
            g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            send_beat(v[i]);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] f1[N], f2[N], f3[N], f4[N], f5[N], fr[N];
        int          ei;
        logic [31:0] em;

        f1 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        f2 = '{5, -3, 7, 7, 0, 0, 0, 0, 0, 0};
        f3 = '{-10, -2, -8, 32'h8000_0000, -5, -7, -3, -4, -6, -9};
        f4 = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        f5 = '{0, 0, 0, 0, 50, 0, 0, 49, 0, -1};

        // Pin the reference model itself
        argmax(f1, ei, em);
        check("model_f1_idx", 32'(ei), 32'd9);
        check("model_f1_max", em, 32'd10);
        argmax(f2, ei, em);
        check("model_f2_idx", 32'(ei), 32'd2);
        argmax(f3, ei, em);
        check("model_f3_idx", 32'(ei), 32'd1);
        check("model_f3_max", em, 32'hFFFF_FFFE);

        rst = 1'b1;
        a_tvalid = 1'b0;
        a_tdata = '0;
        class_tready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_a_tready", 32'(a_tready), 32'd0);
        check("rst_tvalid", 32'(class_tvalid), 32'd0);
        check("rst_tdata", 32'(class_tdata), 32'd0);
        check("rst_tmax", class_tmax, 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_a_tready", 32'(a_tready), 32'd1);

        // Test 1: ascending, back-to-back
        send_frame(f1, 0);
        check("t1_latency_tvalid", 32'(class_tvalid), 32'd1);
        check("t1_tdata", 32'(class_tdata), 32'd9);
        check("t1_tmax", class_tmax, 32'd10);
        @(posedge clk);
        #1;
        check("t1_frame_count", 32'(frame_count), 32'd1);

        // Test 2: tie keeps lower index
        send_frame(f2, 0);
        check("t2_tdata", 32'(class_tdata), 32'd2);
        check("t2_tmax", class_tmax, 32'd7);

        // Test 3: all negative incl. minimum value
        send_frame(f3, 2);
        check("t3_tdata", 32'(class_tdata), 32'd1);
        check("t3_tmax", class_tmax, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        check("t3_frame_count", 32'(frame_count), 32'd3);

        // Test 4: consumer stalls 20 cycles while next frame is offered
        class_tready = 1'b0;
        send_frame(f4, 0);
        fork
            send_frame(f5, 0);
            begin
                repeat (20) @(posedge clk);
                #1;
                check("t4_stall_tvalid", 32'(class_tvalid), 32'd1);
                check("t4_stall_tdata", 32'(class_tdata), 32'd5);
                check("t4_stall_a_tready", 32'(a_tready), 32'd0);
                check("t4_stall_count", 32'(frame_count), 32'd3);
                class_tready = 1'b1;
                @(posedge clk);
                #1;
                check("t4_release_count", 32'(frame_count), 32'd4);
                check("t4_release_a_tready", 32'(a_tready), 32'd1);
            end
        join
        check("t4_f5_tdata", 32'(class_tdata), 32'd4);
        @(posedge clk);
        #1;
        check("t4_f5_count", 32'(frame_count), 32'd5);

        // Reset while a result is pending drops it
        class_tready = 1'b0;
        send_frame(f1, 0);
        pulse_reset();
        check("rstv_tvalid", 32'(class_tvalid), 32'd0);
        check("rstv_count", 32'(frame_count), 32'd0);
        class_tready = 1'b1;

        // Test 5: partial frame discarded by reset
        for (int i = 0; i < 6; i++) send_beat(32'd100 + 32'(i));
        check("t5_busy_mid", 32'(busy), 32'd1);
        pulse_reset();
        check("t5_busy_after_rst", 32'(busy), 32'd0);
        send_frame(f5, 1);
        check("t5_tdata", 32'(class_tdata), 32'd4);
        check("t5_tmax", class_tmax, 32'd50);
        @(posedge clk);
        #1;
        check("t5_frame_count", 32'(frame_count), 32'd1);

        // Test 6: 100 random frames with gaps
        pulse_reset();
        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < N; i++) begin
                fr[i] = $urandom_range(0, 1) ? 32'($urandom) : (32'($urandom_range(0, 20)) - 32'd10);
            end
            send_frame(fr, 5);
        end
        @(posedge clk);
        #1;
        check("t6_frame_count", 32'(frame_count), 32'd100);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
